// File: rtl/rvfi_mem_pkg.sv
// Shared types and elaboration helpers for the bounded-latency memory responder.
package rvfi_mem_pkg;

    localparam int XFER_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } mem_req_t;

    // Ready can never appear before cycle 2, and the forced bound must not undercut the minimum.
    function automatic bit lat_params_ok(input int min_lat, input int max_lat);
        return (min_lat >= 2) && (max_lat >= min_lat);
    endfunction

endpackage

// File: rtl/rvfi_mem_ram.sv
// Word-addressed RAM with per-byte write enables. The read data is presented
// combinationally; the parent registers it into its response.
module rvfi_mem_ram
    import rvfi_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clock,
    input  logic [DEPTH_LOG2-1:0] index,
    input  logic [3:0]            we,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    // Byte-lane writes; contents are deliberately never reset so data survives a reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[index][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/rvfi_mem_responder.sv
// Bounded-latency memory slave for the picorv32 native bus, with sticky
// protocol and range error flags.
//
// state | meaning
// IDLE  | no transfer; a valid request is latched here (cycle 0)
// WAIT  | counting latency; stall_req may extend up to MAX_LAT
// RESP  | mem_ready high for this single cycle; count the transfer
module rvfi_mem_responder
    import rvfi_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int MIN_LAT    = 2,
    parameter int MAX_LAT    = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic                  mem_instr,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wdata,
    input  logic [3:0]            mem_wstrb,
    input  logic                  stall_req,
    output logic                  mem_ready,
    output logic [31:0]           mem_rdata,
    output logic                  proto_err,
    output logic                  range_err,
    output logic [XFER_CNT_W-1:0] xfer_count
);

    localparam int CNT_W = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_LAT);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_LAT);

    if (!lat_params_ok(MIN_LAT, MAX_LAT)) begin : g_bad_lat
        $error("rvfi_mem_responder: illegal MIN_LAT/MAX_LAT combination");
    end

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt, cnt_inc;
    mem_req_t                req, req_nxt;
    logic                    ready_nxt, proto_nxt, range_nxt;
    logic [31:0]             rdata_nxt, ram_rdata;
    logic [XFER_CNT_W-1:0]   count_nxt;
    logic                    in_range, release_now, mismatch;
    logic [3:0]              ram_we;

    assign cnt_inc     = cnt + CNT_W'(1);
    assign in_range    = (req.addr[31:DEPTH_LOG2+2] == '0);
    assign release_now = (state == WAIT) && (cnt_inc >= MIN_C)
                         && (!stall_req || (cnt_inc == MAX_C));
    assign ram_we      = (release_now && in_range) ? req.wstrb : 4'b0000;
    assign mismatch    = !mem_valid || (mem_addr != req.addr) || (mem_wdata != req.wdata)
                         || (mem_wstrb != req.wstrb) || (mem_instr != req.instr);

    rvfi_mem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clock (clock),
        .index (req.addr[DEPTH_LOG2+1:2]),
        .we    (ram_we),
        .wdata (req.wdata),
        .rdata (ram_rdata)
    );

    // Next-state and next-output logic; every output is a register fed from here.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_nxt   = req;
        ready_nxt = 1'b0;
        rdata_nxt = '0;
        proto_nxt = proto_err;
        range_nxt = range_err;
        count_nxt = xfer_count;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    req_nxt   = '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb, instr: mem_instr};
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = WAIT;
                    if (mem_addr[1:0] != 2'b00) proto_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (mismatch) proto_nxt = 1'b1;
                if (release_now) begin
                    ready_nxt = 1'b1;
                    state_nxt = RESP;
                    if (!in_range) range_nxt = 1'b1;
                    else if (req.wstrb == 4'b0000) rdata_nxt = ram_rdata;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            RESP: begin
                if (mismatch) proto_nxt = 1'b1;
                if (xfer_count != '1) count_nxt = xfer_count + XFER_CNT_W'(1);
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            req        <= '0;
            mem_ready  <= 1'b0;
            mem_rdata  <= '0;
            proto_err  <= 1'b0;
            range_err  <= 1'b0;
            xfer_count <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            req        <= req_nxt;
            mem_ready  <= ready_nxt;
            mem_rdata  <= rdata_nxt;
            proto_err  <= proto_nxt;
            range_err  <= range_nxt;
            xfer_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_rvfi_mem_responder.sv
// Directed bench for rvfi_mem_responder (MIN_LAT=2, MAX_LAT=5, DEPTH_LOG2=8).
module tb_rvfi_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        stall_req = 1'b0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        proto_err;
    logic        range_err;
    logic [15:0] xfer_count;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    logic [31:0] rd;

    rvfi_mem_responder #(.DEPTH_LOG2(8), .MIN_LAT(2), .MAX_LAT(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .stall_req  (stall_req),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .proto_err  (proto_err),
        .range_err  (range_err),
        .xfer_count (xfer_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one transfer starting just after a clock edge. lat is the cycle in
    // which mem_ready was seen (-1 on timeout). glitch drops mem_valid in cycle 1.
    task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input bit stall, input bit glitch,
                        output int l, output logic [31:0] r);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        stall_req = stall;
        l = -1;
        r = '0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clock); #1;
            if (mem_ready) begin
                l = c;
                r = mem_rdata;
                break;
            end
            if (glitch && c == 1) mem_valid = 1'b0;
        end
        @(posedge clock); #1;
        check("ready_one_cycle", {31'b0, mem_ready}, 32'd0);
        check("rdata_cleared", mem_rdata, 32'd0);
        mem_valid = 1'b0;
        mem_wstrb = '0;
        stall_req = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", {31'b0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_errs", {30'b0, proto_err, range_err}, 32'd0);
        check("rst_count", {16'b0, xfer_count}, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        xfer(32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, lat, rd);
        check("wr10_lat", lat, 32'd2);
        xfer(32'h10, 32'h0, 4'h0, 1'b0, 1'b0, lat, rd);
        check("rd10_lat", lat, 32'd2);
        check("rd10_data", rd, 32'hDEADBEEF);
        check("rd10_count", {16'b0, xfer_count}, 32'd2);

        xfer(32'h0, 32'h12345678, 4'hF, 1'b0, 1'b0, lat, rd);
        xfer(32'h0, 32'h0, 4'h0, 1'b1, 1'b0, lat, rd);
        check("stall_lat", lat, 32'd5);
        check("stall_data", rd, 32'h12345678);
        check("stall_proto", {31'b0, proto_err}, 32'd0);

        xfer(32'h20, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0, lat, rd);
        xfer(32'h20, 32'h11223344, 4'b0101, 1'b0, 1'b0, lat, rd);
        check("wstrb_lat", lat, 32'd2);
        xfer(32'h20, 32'h0, 4'h0, 1'b0, 1'b0, lat, rd);
        check("wstrb_data", rd, 32'hAA22CC44);

        check("range_before", {31'b0, range_err}, 32'd0);
        xfer(32'h400, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b0, lat, rd);
        check("range_wr_lat", lat, 32'd2);
        check("range_err", {31'b0, range_err}, 32'd1);
        xfer(32'h400, 32'h0, 4'h0, 1'b0, 1'b0, lat, rd);
        check("range_rd_data", rd, 32'd0);
        xfer(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, lat, rd);
        check("range_ram_kept", rd, 32'h12345678);
        check("range_sticky", {31'b0, range_err}, 32'd1);
        check("count_10", {16'b0, xfer_count}, 32'd10);

        xfer(32'h10, 32'h0, 4'h0, 1'b0, 1'b1, lat, rd);
        check("glitch_lat", lat, 32'd2);
        check("glitch_data", rd, 32'hDEADBEEF);
        check("glitch_proto", {31'b0, proto_err}, 32'd1);
        xfer(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, lat, rd);
        check("proto_sticky", {31'b0, proto_err}, 32'd1);

        mem_valid = 1'b1;
        mem_addr  = 32'h0;
        mem_wstrb = 4'h0;
        stall_req = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("midwait_no_ready", {31'b0, mem_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check("midrst_ready", {31'b0, mem_ready}, 32'd0);
        check("midrst_errs", {30'b0, proto_err, range_err}, 32'd0);
        check("midrst_count", {16'b0, xfer_count}, 32'd0);
        mem_valid = 1'b0;
        stall_req = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        xfer(32'h20, 32'h0, 4'h0, 1'b0, 1'b0, lat, rd);
        check("post_rst_lat", lat, 32'd2);
        check("post_rst_data", rd, 32'hAA22CC44);
        check("post_rst_count", {16'b0, xfer_count}, 32'd1);
        check("post_rst_proto", {31'b0, proto_err}, 32'd0);

        xfer(32'h13, 32'h0, 4'h0, 1'b0, 1'b0, lat, rd);
        check("misalign_data", rd, 32'hDEADBEEF);
        check("misalign_proto", {31'b0, proto_err}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
